// File: rtl/mb_add_ctrl_pkg.sv
// rtl/mb_add_ctrl_pkg.sv - shared state encoding, byte width and index sizing for mb_add_ctrl
package mb_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD_AB = 2'd1,
        S_ADD_C  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // A single-byte operand still needs a 1-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mb_add_ctrl_if.sv
// rtl/mb_add_ctrl_if.sv - start/busy/done request and result bundle for mb_add_ctrl
interface mb_add_ctrl_if #(
    parameter int WORDS = 4
);
    import mb_add_ctrl_pkg::*;

    localparam int W = BYTE_W * WORDS;

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    modport master (
        output start, op_a, op_b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/mb_add_ctrl_adder.sv
// rtl/mb_add_ctrl_adder.sv - 8-bit ripple adder (no carry-in) built from half and full adders
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign cout = c0 | c1;
endmodule

module adder_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] sum,
    output logic       cout
);
    logic [7:0] c;

    half_adder u_ha (.a(a[0]), .b(b[0]), .s(sum[0]), .c(c[0]));

    for (genvar i = 1; i < 8; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i-1]),
            .s    (sum[i]),
            .cout (c[i])
        );
    end

    assign cout = c[7];
endmodule

// File: rtl/mb_add_ctrl.sv
// rtl/mb_add_ctrl.sv - multi-byte adder sequencer time-sharing one adder_8bits, two passes per byte LSB first
module mb_add_ctrl
    import mb_add_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mb_add_ctrl_if.slave  bus
);

    localparam int W     = BYTE_W * WORDS;
    localparam int IDX_W = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t              state;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [W-1:0]        sum_r;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic                c1;
    logic [BYTE_W-1:0]   partial;
    logic                busy_r;
    logic                done_r;
    logic                cout_r;

    logic [BYTE_W-1:0]   add_a;
    logic [BYTE_W-1:0]   add_b;
    logic [BYTE_W-1:0]   add_s;
    logic                add_co;

    // Pass 1 feeds the operand bytes, pass 2 folds in the inter-byte carry.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            S_ADD_AB: begin
                add_a = a_reg[idx*BYTE_W +: BYTE_W];
                add_b = b_reg[idx*BYTE_W +: BYTE_W];
            end
            S_ADD_C: begin
                add_a = partial;
                add_b = {{(BYTE_W-1){1'b0}}, carry};
            end
            default: begin
                add_a = '0;
                add_b = '0;
            end
        endcase
    end

    adder_8bits u_adder (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_s),
        .cout (add_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_r   <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            c1      <= 1'b0;
            partial <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            cout_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.op_a;
                        b_reg  <= bus.op_b;
                        idx    <= '0;
                        carry  <= 1'b0;
                        busy_r <= 1'b1;
                        state  <= S_ADD_AB;
                    end
                end
                S_ADD_AB: begin
                    partial <= add_s;
                    c1      <= add_co;
                    state   <= S_ADD_C;
                end
                S_ADD_C: begin
                    // c1 and add_co cannot both be set: a 0xFF partial never carries in pass 1.
                    sum_r[idx*BYTE_W +: BYTE_W] <= add_s;
                    carry <= c1 | add_co;
                    if (idx == LAST_IDX) begin
                        cout_r <= c1 | add_co;
                        done_r <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_ADD_AB;
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_mb_add_ctrl.sv
// tb/tb_mb_add_ctrl.sv - self-checking bench for mb_add_ctrl with WORDS=4 and WORDS=1 instances
module tb_mb_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mb_add_ctrl_if #(.WORDS(4)) bus4 ();
    mb_add_ctrl_if #(.WORDS(1)) bus1 ();

    mb_add_ctrl #(.WORDS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mb_add_ctrl #(.WORDS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle 0 carries start; done must land in cycle 2*WORDS+1 with busy high throughout.
    task automatic op4(input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [32:0] exp;
        logic [31:0] prev;
        int lat;
        int busy_bad;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        prev = bus4.sum;
        bus4.start = 1'b1;
        bus4.op_a  = a;
        bus4.op_b  = b;
        @(negedge clk);
        bus4.start = 1'b0;
        bus4.op_a  = $urandom;
        bus4.op_b  = $urandom;
        lat = 1;
        busy_bad = 0;
        check({tag, "_sum_kept"}, 64'(bus4.sum), 64'(prev));
        while (!bus4.done && lat < 40) begin
            if (!bus4.busy) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (!bus4.busy) busy_bad++;
        check({tag, "_latency"}, 64'(lat), 64'(9));
        check({tag, "_result"}, 64'({bus4.cout, bus4.sum}), 64'(exp));
        check({tag, "_busy"}, 64'(busy_bad), 64'(0));
    endtask

    task automatic op1(input logic [7:0] a, input logic [7:0] b, input string tag);
        logic [8:0] exp;
        int lat;
        exp = {1'b0, a} + {1'b0, b};
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.op_a  = a;
        bus1.op_b  = b;
        @(negedge clk);
        bus1.start = 1'b0;
        bus1.op_a  = 8'($urandom);
        bus1.op_b  = 8'($urandom);
        lat = 1;
        while (!bus1.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(3));
        check({tag, "_result"}, 64'({bus1.cout, bus1.sum}), 64'(exp));
    endtask

    initial begin
        logic [32:0] res;
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        int dcount;
        int dcyc;

        rst_n = 1'b0;
        bus4.start = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
        bus1.start = 1'b0; bus1.op_a = '0; bus1.op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus4.busy), 64'(0));
        check("rst_done", 64'(bus4.done), 64'(0));
        check("rst_sum", 64'({bus4.cout, bus4.sum}), 64'(0));
        check("rst_sum1", 64'({bus1.busy, bus1.done, bus1.cout, bus1.sum}), 64'(0));
        rst_n = 1'b1;

        op4(32'h12345678, 32'h11111111, "basic");
        op4(32'hFFFFFFFF, 32'h00000001, "ripple");
        op4(32'h0000FF01, 32'h000000FF, "pass2_carry");

        held = bus4.sum;
        repeat (3) @(negedge clk);
        check("idle_hold_sum", 64'(bus4.sum), 64'(held));
        check("idle_done_low", 64'(bus4.done), 64'(0));

        // Start pulses while busy (including the DONE cycle) must be dropped.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.op_a  = 32'h80000000;
        bus4.op_b  = 32'h80000000;
        dcount = 0;
        dcyc = 0;
        res = '0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            bus4.start = (c == 3 || c == 9);
            bus4.op_a  = $urandom;
            bus4.op_b  = $urandom;
            if (bus4.done) begin
                dcount++;
                dcyc = c;
                res = {bus4.cout, bus4.sum};
            end
        end
        check("busy_start_done_count", 64'(dcount), 64'(1));
        check("busy_start_done_cycle", 64'(dcyc), 64'(9));
        check("busy_start_result", 64'(res), 64'h1_0000_0000);
        op4(32'hA5A5A5A5, 32'h5A5A5A5B, "back_to_back");

        // Reset in cycle 4 of an operation aborts it silently.
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.op_a  = 32'h0F0F0F0F;
        bus4.op_b  = 32'h01010101;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            bus4.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus4.busy), 64'(0));
        check("abort_done", 64'(bus4.done), 64'(0));
        check("abort_sum", 64'({bus4.cout, bus4.sum}), 64'(0));
        rst_n = 1'b1;
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus4.done) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'(0));
        op4(32'h0F0F0F0F, 32'h01010101, "after_abort");

        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            rb = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFF - ra + 32'($urandom_range(0, 1))) : $urandom;
            op4(ra, rb, "rnd4");
        end
        op1(8'hFF, 8'h01, "w1_carry");
        for (int i = 0; i < 1000; i++) begin
            op1(8'($urandom), 8'($urandom), "rnd1");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
